// File: rtl/pll_reconf_pkg.sv
// Shared state encoding, divider-triple type and pin-encoding helper for pll_reconf_seq.
package pll_reconf_pkg;

    typedef logic [2:0] state_t;

    localparam state_t StRstPll   = 3'd0;
    localparam state_t StWaitLock = 3'd1;
    localparam state_t StStable   = 3'd2;
    localparam state_t StLocked   = 3'd3;
    localparam state_t StFail     = 3'd4;

    typedef struct packed {
        logic [5:0] fdiv;
        logic [5:0] idiv;
        logic [5:0] odiv;
    } div_cfg_t;

    // The PLL takes fdiv/idiv inverted; odiv is already a raw pin code.
    function automatic div_cfg_t to_pin_enc(input div_cfg_t nat);
        div_cfg_t pins;
        pins.fdiv = ~nat.fdiv;
        pins.idiv = ~nat.idiv;
        pins.odiv = nat.odiv;
        return pins;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level, resets to 0.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reconf_seq.sv
// Owns the PLL divider pins: applies a requested setting, pulses PLL reset and qualifies
// LOCK with timeout, retries and a stability window.
module pll_reconf_seq #(
    parameter logic [5:0]  DEF_FDIV            = 6'd9,
    parameter logic [5:0]  DEF_IDIV            = 6'd2,
    parameter logic [5:0]  DEF_ODIV            = 6'b111100,
    parameter int unsigned RESET_CYCLES        = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [5:0] req_fdiv,
    input  logic [5:0] req_idiv,
    input  logic [5:0] req_odiv,
    input  logic       pll_lock,
    output logic [5:0] pll_fdiv,
    output logic [5:0] pll_idiv,
    output logic [5:0] pll_odiv,
    output logic       pll_reset,
    output logic       locked,
    output logic       busy,
    output logic       error,
    output logic       lock_lost,
    output logic [1:0] retry_cnt
);

    import pll_reconf_pkg::*;

    localparam int unsigned RstW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int unsigned TmoW = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
    localparam int unsigned StbW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;

    localparam logic [RstW-1:0] RstLast = RstW'(RESET_CYCLES - 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [StbW-1:0] StbLast = StbW'(LOCK_STABLE_CYCLES - 1);

    localparam div_cfg_t DefNat = '{fdiv: DEF_FDIV, idiv: DEF_IDIV, odiv: DEF_ODIV};

    state_t          state_q, state_d;
    div_cfg_t        div_q, div_d;
    logic [RstW-1:0] rst_cnt_q, rst_cnt_d;
    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [StbW-1:0] stb_cnt_q, stb_cnt_d;
    logic [1:0]      retry_q, retry_d;
    logic            lock_lost_q, lock_lost_d;
    logic            lock_s;
    logic            accept;
    div_cfg_t        req_nat;

    sync2 u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    assign req_ready = (state_q == StLocked) || (state_q == StFail);
    assign accept    = req_valid && req_ready;
    assign req_nat   = '{fdiv: req_fdiv, idiv: req_idiv, odiv: req_odiv};

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        rst_cnt_d   = rst_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        stb_cnt_d   = stb_cnt_q;
        retry_d     = retry_q;
        lock_lost_d = lock_lost_q;

        // Accept takes priority over any lock event in the same cycle.
        if (accept) begin
            div_d       = to_pin_enc(req_nat);
            state_d     = StRstPll;
            rst_cnt_d   = '0;
            retry_d     = 2'd0;
            lock_lost_d = 1'b0;
        end else begin
            case (state_q)
                StRstPll: begin
                    if (rst_cnt_q == RstLast) begin
                        state_d   = StWaitLock;
                        tmo_cnt_d = '0;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 1'b1;
                    end
                end
                StWaitLock: begin
                    if (lock_s) begin
                        state_d   = StStable;
                        stb_cnt_d = '0;
                    end else if (tmo_cnt_q == TmoLast) begin
                        if (32'(retry_q) < MAX_RETRIES) begin
                            retry_d   = retry_q + 2'd1;
                            state_d   = StRstPll;
                            rst_cnt_d = '0;
                        end else begin
                            state_d = StFail;
                        end
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
                StStable: begin
                    // A dropout keeps the timeout count so glitching cannot extend the budget.
                    if (!lock_s) begin
                        state_d = StWaitLock;
                    end else if (stb_cnt_q == StbLast) begin
                        state_d = StLocked;
                    end else begin
                        stb_cnt_d = stb_cnt_q + 1'b1;
                    end
                end
                StLocked: begin
                    if (!lock_s) begin
                        state_d     = StWaitLock;
                        tmo_cnt_d   = '0;
                        retry_d     = 2'd0;
                        lock_lost_d = 1'b1;
                    end
                end
                StFail: begin
                    state_d = StFail;
                end
                default: begin
                    state_d   = StRstPll;
                    rst_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRstPll;
            div_q       <= to_pin_enc(DefNat);
            rst_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            stb_cnt_q   <= '0;
            retry_q     <= 2'd0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            rst_cnt_q   <= rst_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            stb_cnt_q   <= stb_cnt_d;
            retry_q     <= retry_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign pll_fdiv  = div_q.fdiv;
    assign pll_idiv  = div_q.idiv;
    assign pll_odiv  = div_q.odiv;
    assign pll_reset = (state_q == StRstPll);
    assign locked    = (state_q == StLocked);
    assign error     = (state_q == StFail);
    assign busy      = (state_q == StRstPll) || (state_q == StWaitLock) || (state_q == StStable);
    assign lock_lost = lock_lost_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reconf_seq.sv
// Self-checking bench for pll_reconf_seq with a small PLL lock model and cycle-count predictions.
module tb_pll_reconf_seq;

    localparam int RC = 4;
    localparam int TO = 64;
    localparam int ST = 8;
    localparam int MR = 2;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [5:0] req_fdiv, req_idiv, req_odiv;
    logic       pll_lock;
    logic [5:0] pll_fdiv, pll_idiv, pll_odiv;
    logic       pll_reset, locked, busy, error, lock_lost;
    logic [1:0] retry_cnt;

    int         tests = 0;
    int         fails = 0;
    logic       reset_seen;
    logic [5:0] exp_f, exp_i, exp_o;

    always #5 clk = ~clk;

    pll_reconf_seq #(
        .DEF_FDIV            (6'd9),
        .DEF_IDIV            (6'd2),
        .DEF_ODIV            (6'b111100),
        .RESET_CYCLES        (RC),
        .LOCK_TIMEOUT_CYCLES (TO),
        .LOCK_STABLE_CYCLES  (ST),
        .MAX_RETRIES         (MR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_fdiv  (req_fdiv),
        .req_idiv  (req_idiv),
        .req_odiv  (req_odiv),
        .pll_lock  (pll_lock),
        .pll_fdiv  (pll_fdiv),
        .pll_idiv  (pll_idiv),
        .pll_odiv  (pll_odiv),
        .pll_reset (pll_reset),
        .locked    (locked),
        .busy      (busy),
        .error     (error),
        .lock_lost (lock_lost),
        .retry_cnt (retry_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        if (pll_reset) reset_seen = 1'b1;
    endtask

    task automatic set_defaults();
        exp_f = 6'b110110;
        exp_i = 6'b111101;
        exp_o = 6'b111100;
    endtask

    // Present one request while ready; the PLL model drops lock as its reset begins.
    task automatic issue(input logic [5:0] f, input logic [5:0] i, input logic [5:0] o);
        req_valid = 1'b1;
        req_fdiv  = f;
        req_idiv  = i;
        req_odiv  = o;
        pll_lock  = 1'b0;
        tick();
        req_valid = 1'b0;
        exp_f = ~f;
        exp_i = ~i;
        exp_o = o;
    endtask

    task automatic count_reset_high(output int n);
        n = 0;
        while (pll_reset && n < 1000) begin
            n++;
            tick();
        end
    endtask

    // Lock is first sampled high at edge d after the call; optional 1-cycle low glitch at d+g.
    task automatic lock_run(input int d, input int g, output int n);
        n = -1;
        for (int k = 1; k <= 400; k++) begin
            pll_lock = (k >= d) && !(g != 0 && k == d + g);
            tick();
            if (locked) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_fdiv = '0;
        req_idiv = '0;
        req_odiv = '0;
        pll_lock = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        set_defaults();
        tests++;
        if ({pll_fdiv, pll_idiv, pll_odiv} !== {exp_f, exp_i, exp_o}) begin
            fails++;
            $display("FAIL reset_dividers: got %b %b %b expected %b %b %b",
                     pll_fdiv, pll_idiv, pll_odiv, exp_f, exp_i, exp_o);
        end
        tests++;
        if ({pll_reset, busy, req_ready, locked, error, lock_lost, retry_cnt} !== 8'b1100_0000) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 11000000",
                     {pll_reset, busy, req_ready, locked, error, lock_lost, retry_cnt});
        end
        #2 rst_n = 1'b1;
        count_reset_high(n);
        tests++;
        if (n != RC) begin
            fails++;
            $display("FAIL reset_pulse_len: got %0d expected %0d", n, RC);
        end
        lock_run(10, 0, n);
        tests++;
        if (n != 10 + SYNC + ST) begin
            fails++;
            $display("FAIL first_lock_time: got %0d expected %0d", n, 10 + SYNC + ST);
        end
        tests++;
        if ({req_ready, busy, error, pll_fdiv, pll_idiv, pll_odiv} !== {3'b100, exp_f, exp_i, exp_o})
        begin
            fails++;
            $display("FAIL first_locked_state: got rdy=%b busy=%b err=%b f=%b",
                     req_ready, busy, error, pll_fdiv);
        end
    endtask

    task automatic test_reconfig();
        int n, d;
        logic [5:0] f, i, o;
        for (int it = 0; it < 3; it++) begin
            if (it == 0) begin
                f = 6'd12; i = 6'd5; o = 6'b111000;
            end else begin
                f = 6'($urandom_range(0, 63));
                i = 6'($urandom_range(0, 63));
                o = 6'($urandom_range(0, 63));
            end
            issue(f, i, o);
            tests++;
            if ({pll_fdiv, pll_idiv, pll_odiv} !== {exp_f, exp_i, exp_o}) begin
                fails++;
                $display("FAIL reconf_dividers[%0d]: got %b %b %b expected %b %b %b", it,
                         pll_fdiv, pll_idiv, pll_odiv, exp_f, exp_i, exp_o);
            end
            tests++;
            if ({pll_reset, locked, busy, req_ready} !== 4'b1010) begin
                fails++;
                $display("FAIL reconf_flags[%0d]: got %b expected 1010", it,
                         {pll_reset, locked, busy, req_ready});
            end
            count_reset_high(n);
            tests++;
            if (n != RC) begin
                fails++;
                $display("FAIL reconf_pulse_len[%0d]: got %0d expected %0d", it, n, RC);
            end
            d = $urandom_range(3, 30);
            lock_run(d, 0, n);
            tests++;
            if (n != d + SYNC + ST || retry_cnt !== 2'd0) begin
                fails++;
                $display("FAIL reconf_lock_time[%0d]: got %0d retry %0d expected %0d retry 0",
                         it, n, retry_cnt, d + SYNC + ST);
            end
        end
    endtask

    task automatic test_timeout();
        int n, d;
        issue(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        for (int a = 0; a <= MR; a++) begin
            tests++;
            if (retry_cnt !== 2'(a) || !pll_reset) begin
                fails++;
                $display("FAIL retry_at_pulse[%0d]: got retry %0d rst %b expected %0d 1",
                         a, retry_cnt, pll_reset, a);
            end
            count_reset_high(n);
            tests++;
            if (n != RC) begin
                fails++;
                $display("FAIL retry_pulse_len[%0d]: got %0d expected %0d", a, n, RC);
            end
            n = 0;
            while (!pll_reset && !error && n < 1000) begin
                // Offer a competing request while busy; it must be ignored.
                req_valid = (a == 0 && n < 3);
                req_fdiv  = ~exp_f ^ 6'h15;
                n++;
                tick();
            end
            req_valid = 1'b0;
            tests++;
            if (n != TO) begin
                fails++;
                $display("FAIL timeout_len[%0d]: got %0d expected %0d", a, n, TO);
            end
        end
        repeat (3) tick();
        tests++;
        if ({error, busy, req_ready, pll_reset, retry_cnt} !== {4'b1010, 2'(MR)}) begin
            fails++;
            $display("FAIL fail_state: got %b expected 1010%b",
                     {error, busy, req_ready, pll_reset, retry_cnt}, 2'(MR));
        end
        tests++;
        if ({pll_fdiv, pll_idiv, pll_odiv} !== {exp_f, exp_i, exp_o}) begin
            fails++;
            $display("FAIL fail_dividers_held: got %b %b %b expected %b %b %b",
                     pll_fdiv, pll_idiv, pll_odiv, exp_f, exp_i, exp_o);
        end
        issue(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        tests++;
        if ({error, retry_cnt, pll_reset, pll_fdiv} !== {3'b000, 1'b1, exp_f}) begin
            fails++;
            $display("FAIL fail_exit: got err=%b retry=%0d rst=%b f=%b expected 0 0 1 %b",
                     error, retry_cnt, pll_reset, pll_fdiv, exp_f);
        end
        count_reset_high(n);
        d = $urandom_range(3, 30);
        lock_run(d, 0, n);
        tests++;
        if (n != d + SYNC + ST) begin
            fails++;
            $display("FAIL fail_relock_time: got %0d expected %0d", n, d + SYNC + ST);
        end
    endtask

    task automatic test_glitch();
        int n, d, g;
        for (int it = 0; it < 3; it++) begin
            issue(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
            count_reset_high(n);
            d = $urandom_range(3, 15);
            g = (it == 0) ? 6 : $urandom_range(1, ST);
            lock_run(d, g, n);
            // Qualification restarts after the low sample at edge d+g.
            tests++;
            if (n != d + g + 1 + SYNC + ST) begin
                fails++;
                $display("FAIL glitch_lock_time[%0d]: got %0d expected %0d (d=%0d g=%0d)",
                         it, n, d + g + 1 + SYNC + ST, d, g);
            end
        end
    endtask

    task automatic test_lock_loss();
        int n, d;
        reset_seen = 1'b0;
        pll_lock = 1'b0;
        n = 0;
        while (locked && n < 20) begin
            n++;
            tick();
        end
        tests++;
        if (n != 1 + SYNC) begin
            fails++;
            $display("FAIL lock_loss_latency: got %0d expected %0d", n, 1 + SYNC);
        end
        tests++;
        if ({lock_lost, busy, pll_reset, retry_cnt} !== 5'b11000) begin
            fails++;
            $display("FAIL lock_loss_flags: got %b expected 11000",
                     {lock_lost, busy, pll_reset, retry_cnt});
        end
        d = $urandom_range(3, 30);
        lock_run(d, 0, n);
        tests++;
        if (n != d + SYNC + ST) begin
            fails++;
            $display("FAIL lock_loss_relock_time: got %0d expected %0d", n, d + SYNC + ST);
        end
        tests++;
        if ({locked, lock_lost, reset_seen} !== 3'b110) begin
            fails++;
            $display("FAIL lock_loss_after_relock: got %b expected 110",
                     {locked, lock_lost, reset_seen});
        end
    endtask

    task automatic test_back_to_back();
        int n, d;
        issue(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        tests++;
        if (lock_lost !== 1'b0) begin
            fails++;
            $display("FAIL accept_clears_lock_lost: got %b expected 0", lock_lost);
        end
        count_reset_high(n);
        d = $urandom_range(3, 30);
        lock_run(d, 0, n);
        // Lock drop reaches the sequencer on the same edge as the next accept.
        pll_lock = 1'b0;
        tick();
        tick();
        tests++;
        if (locked !== 1'b1) begin
            fails++;
            $display("FAIL b2b_still_locked: got %b expected 1", locked);
        end
        issue(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        tests++;
        if ({lock_lost, pll_reset, locked, pll_fdiv, pll_idiv, pll_odiv}
            !== {3'b010, exp_f, exp_i, exp_o}) begin
            fails++;
            $display("FAIL b2b_accept_wins: got lost=%b rst=%b lck=%b f=%b expected 0 1 0 %b",
                     lock_lost, pll_reset, locked, pll_fdiv, exp_f);
        end
        count_reset_high(n);
        tests++;
        if (n != RC) begin
            fails++;
            $display("FAIL b2b_pulse_len: got %0d expected %0d", n, RC);
        end
        d = $urandom_range(3, 30);
        lock_run(d, 0, n);
        tests++;
        if (n != d + SYNC + ST) begin
            fails++;
            $display("FAIL b2b_lock_time: got %0d expected %0d", n, d + SYNC + ST);
        end
    endtask

    task automatic test_async_reset();
        int n, d;
        issue(6'($urandom_range(10, 63)), 6'($urandom_range(3, 63)), 6'($urandom_range(0, 59)));
        count_reset_high(n);
        repeat (5) tick();
        tests++;
        if ({busy, pll_reset, locked} !== 3'b100) begin
            fails++;
            $display("FAIL pre_reset_waiting: got %b expected 100", {busy, pll_reset, locked});
        end
        #2 rst_n = 1'b0;
        #1;
        set_defaults();
        tests++;
        if ({pll_fdiv, pll_idiv, pll_odiv} !== {exp_f, exp_i, exp_o}) begin
            fails++;
            $display("FAIL async_reset_dividers: got %b %b %b expected %b %b %b",
                     pll_fdiv, pll_idiv, pll_odiv, exp_f, exp_i, exp_o);
        end
        tests++;
        if ({pll_reset, busy, req_ready, locked, error, lock_lost, retry_cnt} !== 8'b1100_0000) begin
            fails++;
            $display("FAIL async_reset_flags: got %b expected 11000000",
                     {pll_reset, busy, req_ready, locked, error, lock_lost, retry_cnt});
        end
        tick();
        #2 rst_n = 1'b1;
        count_reset_high(n);
        tests++;
        if (n != RC) begin
            fails++;
            $display("FAIL post_reset_pulse_len: got %0d expected %0d", n, RC);
        end
        d = $urandom_range(3, 30);
        lock_run(d, 0, n);
        tests++;
        if (n != d + SYNC + ST) begin
            fails++;
            $display("FAIL post_reset_lock_time: got %0d expected %0d", n, d + SYNC + ST);
        end
    endtask

    initial begin
        reset_seen = 1'b0;
        test_reset();
        test_reconfig();
        test_timeout();
        test_glitch();
        test_lock_loss();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d of %0d failed so far", fails, tests);
        $fatal(1);
    end

endmodule
